// File: rtl/seq_detect_pkg.sv
// Shared state encoding and default parameter values for the serial
// pattern detector and its match sub-module.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    SHIFT    = 2'd1,
    COUNT    = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  localparam int         PAT_W_DEF     = 4;
  localparam logic [3:0] PATTERN_DEF   = 4'b1101;
  localparam int         SHIFT_LEN_DEF = 4;

  localparam int PAT_W_MAX     = 16;
  localparam int SHIFT_LEN_MAX = 255;

endpackage

// File: rtl/seq_detect_shift_if.sv
// Serial data / handshake bundle between the detector and its environment.
interface seq_detect_shift_if;
  logic data;
  logic done_counting;
  logic ack;
  logic shift_ena;
  logic counting;
  logic done;

  modport master (
    output data, done_counting, ack,
    input  shift_ena, counting, done
  );

  modport slave (
    input  data, done_counting, ack,
    output shift_ena, counting, done
  );
endinterface

// File: rtl/seq_match.sv
// Pattern history register and match detection; hit looks at the live data
// bit so a detect is known on the same edge that samples the last bit.
module seq_match
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF)
) (
  input  logic clk,
  input  logic resetn,
  input  logic data,
  input  logic enable,
  input  logic clear,
  output logic hit
);

  localparam int            HW        = PAT_W - 1;
  localparam int            FW        = $clog2(PAT_W_MAX);
  localparam logic [FW-1:0] FILL_FULL = FW'(HW);

  logic [HW-1:0]    hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] window;

  assign window = {hist_q, data};
  assign hit    = enable && (window == PATTERN) && (fill_q >= FILL_FULL);

  // clear wins so the bits that formed a match never seed the next one
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (enable) begin
      hist_d = window[HW-1:0];
      if (fill_q != FILL_FULL) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_shift.sv
// Serial pattern detector: on a match, pulse shift_ena for SHIFT_LEN cycles,
// then wait for done_counting and ack before searching again.
module seq_detect_shift
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W     = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(PATTERN_DEF),
  parameter int               SHIFT_LEN = SHIFT_LEN_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  seq_detect_shift_if.slave  bus
);

  localparam int            CW       = $clog2(SHIFT_LEN_MAX + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SHIFT_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_search;
  logic          hit;

  assign in_search = (state_q == SEARCH);

  // A hit both leaves SEARCH and wipes the history on the same edge
  seq_match #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk    (clk),
    .resetn (resetn),
    .data   (bus.data),
    .enable (in_search),
    .clear  (hit),
    .hit    (hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        if (hit) begin
          state_d = SHIFT;
          cnt_d   = CNT_LOAD;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) state_d = COUNT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      COUNT:    if (bus.done_counting) state_d = WAIT_ACK;
      WAIT_ACK: if (bus.ack)           state_d = SEARCH;
      default:  state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.shift_ena = (state_q == SHIFT);
  assign bus.counting  = (state_q == COUNT);
  assign bus.done      = (state_q == WAIT_ACK);

endmodule
